video_stream_writer: RTL and testbench

Front end of the voxel framebuffer write path. Takes the parallel RGB888 video stream (pixel data, data-enable, vsync) from the SBC video interface, converts it to RGB565, and drives the framebuffer write port (write_addr / write_data / write_enab). Double-buffers frames: always writes the back bank and presents the front bank index to the LED driver read side. Swaps banks only on a complete frame.

---
 rtl/video_pkg.sv | 32 +++
 rtl/edge_detect.sv | 29 ++
 rtl/video_stream_writer.sv | 217 +++++++++++++++++++++
 tb/tb_video_stream_writer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and helpers for the video framebuffer write path.
// Holds frame geometry defaults, the RGB565 word layout and the writer FSM states.
package video_pkg;

    localparam int FRAME_W_DEF = 1920;
    localparam int FRAME_H_DEF = 40;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LINE = 2'd1,
        ST_ACTIVE    = 2'd2,
        ST_COMMIT    = 2'd3
    } wr_state_t;

    // Truncating conversion: keep the top 5/6/5 bits of each channel.
    function automatic rgb565_t rgb888_to_565(input logic [23:0] rgb);
        rgb565_t    px;
        logic [7:0] unused_lsbs;
        px.r        = rgb[23:19];
        px.g        = rgb[15:10];
        px.b        = rgb[7:3];
        unused_lsbs = {rgb[18:16], rgb[9:8], rgb[2:0]};
        return px;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Registers a single-bit input once and reports rising/falling edges of the
// registered value against its previous sample.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic r_q;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_q    <= i_d;
            r_prev <= r_q;
        end
    end

    assign o_q    = r_q;
    assign o_rise = r_q & ~r_prev;
    assign o_fall = ~r_q & r_prev;

endmodule

// File: rtl/video_stream_writer.sv
// RGB888 video stream to RGB565 framebuffer writer with double-buffered banks.
// Writes go to the back bank; the front bank index flips only on a complete frame.
module video_stream_writer
    import video_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int FRAME_H = FRAME_H_DEF,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [23:0]       i_rgb,
    input  logic              i_de,
    input  logic              i_vsync,
    output logic [ADDR_W-1:0] o_write_addr,
    output logic [15:0]       o_write_data,
    output logic              o_write_enab,
    output logic              o_read_bank,
    output logic              o_frame_done,
    output logic              o_err_overrun,
    output logic              o_err_short,
    input  logic              i_err_clr
);

    localparam int X_W = $clog2(FRAME_W + 1);
    localparam int Y_W = $clog2(FRAME_H + 1);
    localparam logic [X_W-1:0]    X_LAST      = X_W'(FRAME_W);
    localparam logic [Y_W-1:0]    Y_LAST      = Y_W'(FRAME_H);
    localparam logic [ADDR_W-1:0] LINE_STEP   = ADDR_W'(FRAME_W);
    localparam logic [ADDR_W-1:0] BANK_OFFSET = ADDR_W'(FRAME_W * FRAME_H);

    logic w_de;
    logic w_de_rise;
    logic w_de_fall;
    logic w_vs_rise;
    logic w_unused_vs_q;
    logic w_unused_vs_fall;

    edge_detect u_vsync_edge (
        .clk    (clk),
        .rst    (rst),
        .i_d    (i_vsync),
        .o_q    (w_unused_vs_q),
        .o_rise (w_vs_rise),
        .o_fall (w_unused_vs_fall)
    );

    edge_detect u_de_edge (
        .clk    (clk),
        .rst    (rst),
        .i_d    (i_de),
        .o_q    (w_de),
        .o_rise (w_de_rise),
        .o_fall (w_de_fall)
    );

    // Pixel data is delayed alongside de so it lines up with the registered strobe.
    logic [23:0] r_rgb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= i_rgb;
        end
    end

    wr_state_t         r_state;
    wr_state_t         w_state_next;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [ADDR_W-1:0] r_line_base;
    logic              r_read_bank;
    logic [ADDR_W-1:0] r_write_addr;
    logic [15:0]       r_write_data;
    logic              r_write_enab;
    logic              r_frame_done;
    logic              r_err_overrun;
    logic              r_err_short;

    logic              w_line_last;
    logic [ADDR_W-1:0] w_bank_base;

    assign w_line_last = ((r_y + Y_W'(1)) == Y_LAST);
    assign w_bank_base = r_read_bank ? '0 : BANK_OFFSET;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A vsync edge always (re)starts a frame; in COMMIT it lands after the swap.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_vs_rise) w_state_next = ST_WAIT_LINE;
            end
            ST_WAIT_LINE: begin
                if (w_vs_rise)      w_state_next = ST_WAIT_LINE;
                else if (w_de_rise) w_state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (w_vs_rise)      w_state_next = ST_WAIT_LINE;
                else if (w_de_fall) w_state_next = w_line_last ? ST_COMMIT : ST_WAIT_LINE;
            end
            ST_COMMIT: begin
                w_state_next = w_vs_rise ? ST_WAIT_LINE : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    logic [X_W-1:0]    w_x_next;
    logic [Y_W-1:0]    w_y_next;
    logic [ADDR_W-1:0] w_line_base_next;
    logic              w_read_bank_next;
    logic [ADDR_W-1:0] w_write_addr_next;
    logic [15:0]       w_write_data_next;
    logic              w_write_enab_next;
    logic              w_frame_done_next;
    logic              w_overrun_set;
    logic              w_short_set;

    always_comb begin
        w_x_next          = r_x;
        w_y_next          = r_y;
        w_line_base_next  = r_line_base;
        w_read_bank_next  = r_read_bank;
        w_write_addr_next = r_write_addr;
        w_write_data_next = r_write_data;
        w_write_enab_next = 1'b0;
        w_frame_done_next = 1'b0;
        w_overrun_set     = 1'b0;
        w_short_set       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_vs_rise) begin
                    w_x_next         = '0;
                    w_y_next         = '0;
                    w_line_base_next = '0;
                end
            end
            ST_WAIT_LINE, ST_ACTIVE: begin
                if (w_vs_rise) begin
                    w_short_set      = 1'b1;
                    w_x_next         = '0;
                    w_y_next         = '0;
                    w_line_base_next = '0;
                end else if ((r_state == ST_ACTIVE) && w_de_fall) begin
                    w_x_next         = '0;
                    w_y_next         = r_y + Y_W'(1);
                    w_line_base_next = r_line_base + LINE_STEP;
                end else if (w_de && ((r_state == ST_ACTIVE) || w_de_rise)) begin
                    // The first pixel of a line is written in the cycle de rises.
                    if (r_x == X_LAST) begin
                        w_overrun_set = 1'b1;
                    end else begin
                        w_write_enab_next = 1'b1;
                        w_write_addr_next = w_bank_base + r_line_base + ADDR_W'(r_x);
                        w_write_data_next = rgb888_to_565(r_rgb);
                        w_x_next          = r_x + X_W'(1);
                    end
                end
            end
            ST_COMMIT: begin
                w_read_bank_next  = ~r_read_bank;
                w_frame_done_next = 1'b1;
                w_x_next          = '0;
                w_y_next          = '0;
                w_line_base_next  = '0;
            end
            default: begin
                w_x_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x           <= '0;
            r_y           <= '0;
            r_line_base   <= '0;
            r_read_bank   <= 1'b0;
            r_write_addr  <= '0;
            r_write_data  <= '0;
            r_write_enab  <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_short   <= 1'b0;
        end else begin
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_line_base   <= w_line_base_next;
            r_read_bank   <= w_read_bank_next;
            r_write_addr  <= w_write_addr_next;
            r_write_data  <= w_write_data_next;
            r_write_enab  <= w_write_enab_next;
            r_frame_done  <= w_frame_done_next;
            // A new error beats a simultaneous clear.
            r_err_overrun <= w_overrun_set | (r_err_overrun & ~i_err_clr);
            r_err_short   <= w_short_set   | (r_err_short   & ~i_err_clr);
        end
    end

    assign o_write_addr  = r_write_addr;
    assign o_write_data  = r_write_data;
    assign o_write_enab  = r_write_enab;
    assign o_read_bank   = r_read_bank;
    assign o_frame_done  = r_frame_done;
    assign o_err_overrun = r_err_overrun;
    assign o_err_short   = r_err_short;

endmodule

// File: tb/tb_video_stream_writer.sv
// Bench for video_stream_writer on a reduced 8x4 frame: a frame-level model
// predicts every write strobe, frame_done pulse and bank flip, checked each cycle.
module tb_video_stream_writer;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int AW = 32;
    localparam int FS = W * H;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [23:0]   i_rgb = '0;
    logic          i_de = 1'b0;
    logic          i_vsync = 1'b0;
    logic          i_err_clr = 1'b0;
    logic [AW-1:0] o_write_addr;
    logic [15:0]   o_write_data;
    logic          o_write_enab;
    logic          o_read_bank;
    logic          o_frame_done;
    logic          o_err_overrun;
    logic          o_err_short;

    always #5 clk = ~clk;

    video_stream_writer #(.FRAME_W(W), .FRAME_H(H), .ADDR_W(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_rgb         (i_rgb),
        .i_de          (i_de),
        .i_vsync       (i_vsync),
        .o_write_addr  (o_write_addr),
        .o_write_data  (o_write_data),
        .o_write_enab  (o_write_enab),
        .o_read_bank   (o_read_bank),
        .o_frame_done  (o_frame_done),
        .o_err_overrun (o_err_overrun),
        .o_err_short   (o_err_short),
        .i_err_clr     (i_err_clr)
    );

    typedef struct {
        int          due;
        logic [31:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t  wq[$];
    int   fq[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_we = 0;
    int   n_fd = 0;
    logic exp_rb = 1'b0;

    // Frame-level model state, advanced by the stimulus tasks.
    bit m_in_frame = 0;
    bit m_rb = 0;
    bit m_ovr = 0;
    bit m_short = 0;
    int m_line = 0;
    int m_x = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] to565(input logic [23:0] c);
        return {c[23:19], c[15:10], c[7:3]};
    endfunction

    function automatic logic [23:0] pix(input int line, input int k);
        logic [7:0] r, g, b;
        r = 8'(line * 37 + k * 11 + 1);
        g = 8'(k * 29 + 5);
        b = 8'(line * 53 + k * 7 + 3);
        return {r, g, b};
    endfunction

    // Compare process: one sample per cycle, 1 time unit after the rising edge.
    initial begin
        logic exp_we;
        logic exp_fd;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                wq.delete();
                fq.delete();
                exp_rb = 1'b0;
            end else begin
                exp_we = (wq.size() > 0) && (wq[0].due == cyc);
                check("write_enab", o_write_enab, exp_we);
                if (exp_we && o_write_enab) begin
                    check("write_addr", o_write_addr, wq[0].addr);
                    check("write_data", o_write_data, wq[0].data);
                end
                if ((wq.size() > 0) && (wq[0].due <= cyc)) void'(wq.pop_front());
                exp_fd = (fq.size() > 0) && (fq[0] == cyc);
                if ((fq.size() > 0) && (fq[0] <= cyc)) void'(fq.pop_front());
                if (exp_fd) exp_rb = ~exp_rb;
                check("frame_done", o_frame_done, exp_fd);
                check("read_bank", o_read_bank, exp_rb);
                if (o_write_enab) n_we++;
                if (o_frame_done) n_fd++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_de = 1'b0;
        end
    endtask

    task automatic drive_pixel(input logic [23:0] c);
        @(negedge clk);
        i_de  = 1'b1;
        i_rgb = c;
        if (m_in_frame) begin
            if (m_x < W) wq.push_back('{cyc + 2, 32'((m_rb ? 0 : FS) + m_line * W + m_x), to565(c)});
            else m_ovr = 1;
            m_x++;
        end
    endtask

    task automatic end_line(input int gap);
        @(negedge clk);
        i_de = 1'b0;
        if (m_in_frame) begin
            m_line++;
            m_x = 0;
            if (m_line == H) begin
                fq.push_back(cyc + 3);
                m_rb       = ~m_rb;
                m_in_frame = 0;
                m_line     = 0;
            end
        end
        idle(gap - 1);
    endtask

    task automatic full_line(input int line, input int n);
        for (int k = 0; k < n; k++) drive_pixel(pix(line, k));
        end_line(3);
    endtask

    task automatic vsync_pulse();
        @(negedge clk);
        i_vsync = 1'b1;
        i_de    = 1'b0;
        if (m_in_frame) m_short = 1;
        m_in_frame = 1;
        m_line     = 0;
        m_x        = 0;
        @(negedge clk);
        i_vsync = 1'b0;
        idle(3);
    endtask

    // Three pixels opening a line, with literal checks on exact 2-cycle latency.
    task automatic pinned_triple(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c,
                                 input logic [31:0] base, input logic [15:0] da, input logic [15:0] db);
        drive_pixel(a);
        @(posedge clk); #1;
        check("pin_latency_not_1", o_write_enab, 1'b0);
        drive_pixel(b);
        @(posedge clk); #1;
        check("pin_enab", o_write_enab, 1'b1);
        check("pin_addr0", o_write_addr, base);
        check("pin_data0", o_write_data, da);
        drive_pixel(c);
        @(posedge clk); #1;
        check("pin_addr1", o_write_addr, base + 32'd1);
        check("pin_data1", o_write_data, db);
    endtask

    task automatic pinned_frame(input logic [31:0] base);
        pinned_triple(24'hFF8040, 24'h07030F, pix(0, 2), base, 16'hFC08, 16'h0001);
        for (int k = 3; k < W; k++) drive_pixel(pix(0, k));
        end_line(3);
        for (int l = 1; l < H; l++) full_line(l, W);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, o_write_addr, 32'd0);
        check({tag, "_data"}, o_write_data, 32'd0);
        check({tag, "_enab"}, o_write_enab, 32'd0);
        check({tag, "_read_bank"}, o_read_bank, 32'd0);
        check({tag, "_frame_done"}, o_frame_done, 32'd0);
        check({tag, "_err_overrun"}, o_err_overrun, 32'd0);
        check({tag, "_err_short"}, o_err_short, 32'd0);
    endtask

    initial begin
        int we0;
        int fd0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // de activity before any vsync must not write.
        we0 = n_we;
        for (int k = 0; k < 6; k++) drive_pixel(pix(9, k));
        end_line(3);
        idle(3);
        check("idle_no_writes", 32'(n_we - we0), 32'd0);

        // Nominal frame into bank 1.
        we0 = n_we; fd0 = n_fd;
        vsync_pulse();
        pinned_frame(32'd32);
        idle(4);
        check("f1_writes", 32'(n_we - we0), 32'd32);
        check("f1_frame_done", 32'(n_fd - fd0), 32'd1);
        check("f1_read_bank", o_read_bank, 1'b1);

        // Bank 0 frame with an overrun line and a short line.
        we0 = n_we; fd0 = n_fd;
        vsync_pulse();
        pinned_triple(24'hFF8040, 24'h07030F, pix(0, 2), 32'd0, 16'hFC08, 16'h0001);
        for (int k = 3; k < W; k++) drive_pixel(pix(0, k));
        end_line(3);
        full_line(1, W + 2);
        idle(2);
        check("overrun_set", o_err_overrun, 1'b1);
        check("overrun_model", o_err_overrun, m_ovr);
        full_line(2, W);
        full_line(3, 5);
        idle(4);
        check("f2_writes", 32'(n_we - we0), 32'd29);
        check("f2_frame_done", 32'(n_fd - fd0), 32'd1);
        check("f2_read_bank", o_read_bank, 1'b0);
        @(negedge clk); i_err_clr = 1'b1;
        @(negedge clk); i_err_clr = 1'b0;
        m_ovr = 0; m_short = 0;
        idle(1);
        check("overrun_cleared", o_err_overrun, 1'b0);

        // Short frame: vsync after 2 lines abandons the frame, same back bank.
        we0 = n_we; fd0 = n_fd;
        vsync_pulse();
        full_line(0, W);
        full_line(1, W);
        vsync_pulse();
        check("short_set", o_err_short, 1'b1);
        check("short_model", o_err_short, m_short);
        check("short_no_done", 32'(n_fd - fd0), 32'd0);
        check("short_read_bank", o_read_bank, 1'b0);
        pinned_triple(24'h07030F, 24'hFF8040, pix(0, 2), 32'd32, 16'h0001, 16'hFC08);
        for (int k = 3; k < W; k++) drive_pixel(pix(0, k));
        end_line(3);
        for (int l = 1; l < H; l++) full_line(l, W);
        idle(4);
        check("short_total_writes", 32'(n_we - we0), 32'd48);
        check("short_then_done", 32'(n_fd - fd0), 32'd1);
        check("short_sticky", o_err_short, 1'b1);
        check("after_short_read_bank", o_read_bank, 1'b1);

        // Mid-frame asynchronous reset.
        vsync_pulse();
        full_line(0, W);
        full_line(1, W);
        for (int k = 0; k < 3; k++) drive_pixel(pix(2, k));
        @(negedge clk);
        i_de = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_all_zero("midrst");
        m_in_frame = 0; m_rb = 0; m_ovr = 0; m_short = 0; m_line = 0; m_x = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        we0 = n_we; fd0 = n_fd;
        full_line(3, W);
        idle(3);
        check("post_rst_no_writes", 32'(n_we - we0), 32'd0);

        vsync_pulse();
        pinned_frame(32'd32);
        idle(10);
        check("post_rst_writes", 32'(n_we - we0), 32'd32);
        check("post_rst_done", 32'(n_fd - fd0), 32'd1);
        check("final_read_bank", o_read_bank, 1'b1);
        check("pending_writes", 32'(wq.size()), 32'd0);
        check("pending_done", 32'(fq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
